fifo_rptr_empty: RTL
====================

FIFO_RPTR_EMPTY -- requirements
Module: fifo_rptr_empty

Interface
REQ-001 SHALL have parameter ASIZE, default 4, giving the number of memory address bits (DEPTH = 2^ASIZE).
REQ-002 SHALL have parameter AE_LEVEL, default 2, the almost-empty threshold in words.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth for the write pointer (minimum 2).
REQ-004 SHALL have port rclk, input, 1 bit: read-domain clock, rising edge; the only clock.
REQ-005 SHALL have port rrst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port rinc, input, 1 bit: consumer read request.
REQ-007 SHALL have port wptr, input, ASIZE+1 bits: Gray-coded write pointer from the write domain, asynchronous to rclk.
REQ-008 SHALL have port ren, output, 1 bit: memory read enable, equal to rinc & ~rempty.
REQ-009 SHALL have port raddr, output, ASIZE bits: memory read address.
REQ-010 SHALL have port rptr, output, ASIZE+1 bits: registered Gray read pointer, for export to the write domain.
REQ-011 SHALL have port rempty, output, 1 bit: FIFO empty.
REQ-012 SHALL have port raempty, output, 1 bit: level <= AE_LEVEL.
REQ-013 SHALL have port rlevel, output, ASIZE+1 bits: words available, range 0..DEPTH.
REQ-014 SHALL have port runderflow, output, 1 bit: sticky read-while-empty error.

Function
REQ-015 SHALL keep an ASIZE+1-bit binary counter rbin; rbin_next = rbin + (rinc & ~rempty), modulo 2^(ASIZE+1).
REQ-016 SHALL drive raddr = rbin[ASIZE-1:0] combinationally, so the memory's fall-through read presents the head word in the same cycle.
REQ-017 SHALL register rptr <= rbin_next ^ (rbin_next >> 1).
REQ-018 SHALL pass wptr through SYNC_STAGES rclk flops to produce wq_ptr; no logic SHALL sit between the stages.
REQ-019 SHALL register rempty <= (Gray(rbin_next) == wq_ptr).
REQ-020 SHALL convert wq_ptr Gray to binary wq_bin and register rlevel <= wq_bin - rbin_next, using ASIZE+1-bit modular subtraction.
REQ-021 SHALL register raempty <= (wq_bin - rbin_next) <= AE_LEVEL.
REQ-022 SHALL deassert rempty exactly SYNC_STAGES+1 rclk edges after a wptr change is first sampled.
REQ-023 SHALL NOT advance rbin on rinc while rempty=1; with no read and no wptr change, all outputs SHALL hold.
REQ-024 On simultaneous read and write-pointer advance, rlevel SHALL be unchanged.
REQ-025 On pointer wrap (rbin 2^(ASIZE+1)-1 to 0), raddr SHALL wrap to 0 and flags SHALL remain correct.

Reset
REQ-026 rrst_n=0 SHALL asynchronously force rbin=0, rptr=0, all synchronizer flops=0, rempty=1, raempty=1, rlevel=0, runderflow=0.
REQ-027 Reset deassertion SHALL be synchronous to rclk; the first update SHALL occur on the first rclk edge after deassertion.
REQ-028 Reset asserted mid-stream SHALL discard the in-flight read with no partial pointer update.

Configuration
REQ-029 With FIFO_UNDERFLOW_FLAG_EN defined, rinc=1 while rempty=1 SHALL set runderflow on the next edge; runderflow SHALL clear only on reset.
REQ-030 Without FIFO_UNDERFLOW_FLAG_EN, runderflow SHALL be tied 0 and no flop SHALL be inferred for it; pointer behaviour SHALL be identical.

Structure
REQ-031 A shared package fifo_pkg SHALL hold the Gray/binary conversion functions and default ASIZE and AE_LEVEL constants.
REQ-032 The synchronizer SHALL be sub-module fifo_sync_w2r, with parameters SYNC_STAGES and WIDTH=ASIZE+1; it is reused for the read-to-write pointer crossing.

Verification (ASIZE=4, AE_LEVEL=2, SYNC_STAGES=2)
REQ-033 Reset: rrst_n=0 with no clock -> raddr=0, rptr=0, rempty=1, raempty=1, rlevel=0, runderflow=0 immediately.
REQ-034 wptr 5'b00000 to 5'b00001, held -> rempty falls on the 3rd rclk edge; rlevel=1; raempty=1.
REQ-035 wptr=5'b11000 (binary 16, full), then 16 cycles of rinc=1:
- raddr steps 0..15 and back to 0.
- rptr ends at 5'b11000.
- raempty rises when rlevel=2.
- rempty=1 after the 16th read.
REQ-036 rinc=1 for 3 cycles while empty -> rptr unchanged; runderflow=1 and stays 1 until rrst_n=0 (macro defined); runderflow stays 0 (macro undefined).
REQ-037 With rlevel=5, assert rinc=1 and advance wptr by one in the same cycle -> rlevel stays 5 after settling.
REQ-038 With rlevel=8 mid-read, drop rrst_n between edges -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary pointer conversion and default geometry.
package fifo_pkg;

  localparam int FIFO_ASIZE_DEF    = 4;
  localparam int FIFO_AE_LEVEL_DEF = 2;
  localparam int PTR_MAX_W         = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  // Callers zero-extend narrower pointers in and truncate the result back.
  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync_w2r.sv
// Multi-flop pointer synchronizer; plain flop chain with nothing between stages.
module fifo_sync_w2r
  import fifo_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = FIFO_ASIZE_DEF + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_rptr_empty.sv
// Async-FIFO read-side pointer, empty/almost-empty flags and fill level.
// Optional sticky underflow flag enabled by defining FIFO_UNDERFLOW_FLAG_EN.
module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int ASIZE       = FIFO_ASIZE_DEF,
  parameter int AE_LEVEL    = FIFO_AE_LEVEL_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rinc,
  input  logic [ASIZE:0]   wptr,
  output logic             ren,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic             raempty,
  output logic [ASIZE:0]   rlevel,
  output logic             runderflow
);

  localparam int PW = ASIZE + 1;
  localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_rlevel;
  logic          r_rempty;
  logic          r_raempty;

  logic          w_ren;
  logic [PW-1:0] w_rbin_next;
  logic [PW-1:0] w_rgray_next;
  logic [PW-1:0] w_wq_ptr;
  logic [PW-1:0] w_wq_bin;
  logic [PW-1:0] w_level_next;

  assign w_ren        = rinc & ~r_rempty;
  assign w_rbin_next  = r_rbin + PW'(w_ren);
  assign w_rgray_next = PW'(bin2gray(ptr_max_t'(w_rbin_next)));

  fifo_sync_w2r #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (PW)
  ) u_sync_w2r (
    .i_clk   (rclk),
    .i_rst_n (rrst_n),
    .i_d     (wptr),
    .o_q     (w_wq_ptr)
  );

  assign w_wq_bin = PW'(gray2bin(ptr_max_t'(w_wq_ptr)));
  // Modular difference is correct across pointer wrap since level never exceeds DEPTH.
  assign w_level_next = w_wq_bin - w_rbin_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin    <= '0;
      r_rptr    <= '0;
      r_rempty  <= 1'b1;
      r_raempty <= 1'b1;
      r_rlevel  <= '0;
    end else begin
      r_rbin    <= w_rbin_next;
      r_rptr    <= w_rgray_next;
      r_rempty  <= (w_rgray_next == w_wq_ptr);
      r_rlevel  <= w_level_next;
      r_raempty <= (w_level_next <= AE_THR);
    end
  end

`ifdef FIFO_UNDERFLOW_FLAG_EN
  logic r_runderflow;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_runderflow <= 1'b0;
    end else if (rinc && r_rempty) begin
      r_runderflow <= 1'b1;
    end
  end

  assign runderflow = r_runderflow;
`else
  assign runderflow = 1'b0;
`endif

  assign ren     = w_ren;
  assign raddr   = r_rbin[ASIZE-1:0];
  assign rptr    = r_rptr;
  assign rempty  = r_rempty;
  assign raempty = r_raempty;
  assign rlevel  = r_rlevel;

endmodule
